demux1to64_stream: RTL and testbench

Registered, flow-controlled 1-to-N demultiplexer: the distribution-side counterpart of the registered 64-to-1 mux tree. One input stream of DATA_W-bit words, each tagged with a lane select, is steered to one of N_OUT independently back-pressured output lanes. It sits between a single producer and an array of per-lane consumers. It provides one input skid stage, one holding register per lane, per-lane ordering, and out-of-range select detection.

---
 rtl/demux1to64_stream.sv | 108 ++++++++++
 tb/tb_demux1to64_stream.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to64_stream.sv
// Registered 1-to-N stream demultiplexer: a single input skid register (stage A)
// feeds N_OUT independently back-pressured lane holding registers (stage B).
module demux1to64_stream #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 64,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [DATA_W-1:0]       i_in_data,
  input  logic [SEL_W-1:0]        i_in_sel,
  output logic [N_OUT-1:0]        o_out_valid,
  input  logic [N_OUT-1:0]        i_out_ready,
  output logic [N_OUT*DATA_W-1:0] o_out_data,
  output logic                    o_err_sel_oor,
  output logic [15:0]             o_drop_cnt
);

  // One extra bit so the range compare stays meaningful when N_OUT is a power of two.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);
  localparam logic [15:0]    CNT_MAX = 16'hFFFF;

  logic                           r_a_valid;
  logic [DATA_W-1:0]              r_a_data;
  logic [SEL_W-1:0]               r_a_sel;
  logic [N_OUT-1:0]               r_lane_valid;
  logic [N_OUT-1:0][DATA_W-1:0]   r_lane_data;
  logic                           r_err_sel_oor;
  logic [15:0]                    r_drop_cnt;

  logic [N_OUT-1:0]               w_drain;
  logic [N_OUT-1:0]               w_lane_free;
  logic [N_OUT-1:0]               w_sel_hot;
  logic [N_OUT-1:0]               w_lane_load;
  logic                           w_a_oor;
  logic                           w_a_advance;
  logic                           w_discard;
  logic                           w_accept;

  // Stage A advance decision; in_ready depends on out_ready but never on in_valid.
  always_comb begin
    w_drain     = r_lane_valid & i_out_ready;
    w_lane_free = ~r_lane_valid | w_drain;
    w_a_oor     = ({1'b0, r_a_sel} >= N_OUT_L);
    w_sel_hot   = {N_OUT{1'b0}};
    for (int k = 0; k < N_OUT; k++) begin
      w_sel_hot[k] = (r_a_sel == SEL_W'(k));
    end
    w_a_advance = r_a_valid & (w_a_oor | (|(w_sel_hot & w_lane_free)));
    w_discard   = w_a_advance & w_a_oor;
    w_lane_load = {N_OUT{w_a_advance & ~w_a_oor}} & w_sel_hot;
    o_in_ready  = ~r_a_valid | w_a_advance;
    w_accept    = i_in_valid & o_in_ready;
  end

  // Stage A skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= {DATA_W{1'b0}};
      r_a_sel   <= {SEL_W{1'b0}};
    end else if (w_accept) begin
      r_a_valid <= 1'b1;
      r_a_data  <= i_in_data;
      r_a_sel   <= i_in_sel;
    end else if (w_a_advance) begin
      r_a_valid <= 1'b0;
    end
  end

  // Lane holding registers: a refill takes priority over a drain, so no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_valid <= {N_OUT{1'b0}};
      r_lane_data  <= {(N_OUT*DATA_W){1'b0}};
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (w_lane_load[k]) begin
          r_lane_valid[k] <= 1'b1;
          r_lane_data[k]  <= r_a_data;
        end else if (w_drain[k]) begin
          r_lane_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range discard pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sel_oor <= 1'b0;
      r_drop_cnt    <= 16'd0;
    end else begin
      r_err_sel_oor <= w_discard;
      if (w_discard && (r_drop_cnt != CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign o_out_valid   = r_lane_valid;
  assign o_out_data    = r_lane_data;
  assign o_err_sel_oor = r_err_sel_oor;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_demux1to64_stream.sv
// Self-checking bench for demux1to64_stream: directed scenarios on a 64-lane
// instance, discard/saturation and randomized scoreboard traffic on a 48-lane one.
module tb_demux1to64_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         v64, ir64, e64;
  logic [7:0]   d64;
  logic [5:0]   s64;
  logic [63:0]  ov64, or64;
  logic [511:0] od64;
  logic [15:0]  dc64;

  logic         v48, ir48, e48;
  logic [7:0]   d48;
  logic [5:0]   s48;
  logic [47:0]  ov48, or48;
  logic [383:0] od48;
  logic [15:0]  dc48;

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;
  logic [7:0] exp_q [0:47][$];

  demux1to64_stream #(.DATA_W(8), .N_OUT(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(v64), .o_in_ready(ir64), .i_in_data(d64), .i_in_sel(s64),
    .o_out_valid(ov64), .i_out_ready(or64), .o_out_data(od64),
    .o_err_sel_oor(e64), .o_drop_cnt(dc64)
  );

  demux1to64_stream #(.DATA_W(8), .N_OUT(48)) dut48 (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(v48), .o_in_ready(ir48), .i_in_data(d48), .i_in_sel(s48),
    .o_out_valid(ov48), .i_out_ready(or48), .o_out_data(od48),
    .o_err_sel_oor(e48), .o_drop_cnt(dc48)
  );

  function automatic logic [7:0] lane64(input int k);
    return od64[k*8 +: 8];
  endfunction

  function automatic logic [7:0] lane48(input int k);
    return od48[k*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [63:0] exp;
    rst_n = 1'b0;
    v64 = 1'b0; d64 = 8'd0; s64 = 6'd0; or64 = {64{1'b1}};
    v48 = 1'b0; d48 = 8'd0; s48 = 6'd0; or48 = {48{1'b1}};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL reset_in_ready act=%b exp=1", ir64); end
    checks++; if (ov64 !== 64'd0) begin failures++; $display("FAIL reset_out_valid act=%h exp=0", ov64); end
    checks++; if (od64 !== 512'd0) begin failures++; $display("FAIL reset_out_data act=%h exp=0", od64); end
    checks++; if (e64 !== 1'b0 || dc64 !== 16'd0) begin failures++; $display("FAIL reset_err_cnt act=%b/%h exp=0/0", e64, dc64); end
    checks++; if (ir48 !== 1'b1 || ov48 !== 48'd0 || dc48 !== 16'd0) begin failures++; $display("FAIL reset_dut48 act=%b/%h/%h exp=1/0/0", ir48, ov48, dc48); end
    // park a word in lane 7, then reset asynchronously while it is held
    or64[7] = 1'b0; v64 = 1'b1; s64 = 6'd7; d64 = 8'h77;
    tick();
    v64 = 1'b0;
    tick();
    #1;
    exp = 64'd1 << 7;
    checks++; if (ov64 !== exp) begin failures++; $display("FAIL lane7_held act=%h exp=%h", ov64, exp); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ov64 !== 64'd0) begin failures++; $display("FAIL async_reset_drop act=%h exp=0", ov64); end
    @(negedge clk);
    rst_n = 1'b1; or64 = {64{1'b1}};
    v64 = 1'b1; s64 = 6'd9; d64 = 8'h99;
    #1;
    checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL first_accept_ready act=%b exp=1", ir64); end
    tick();
    v64 = 1'b0;
    tick();
    #1;
    exp = 64'd1 << 9;
    checks++; if (ov64 !== exp || lane64(9) !== 8'h99) begin failures++; $display("FAIL first_accept_out act=%h/%h exp=%h/99", ov64, lane64(9), exp); end
    tick();
  endtask

  task automatic test_single();
    logic [63:0] exp;
    v64 = 1'b1; s64 = 6'd5; d64 = 8'hA5;
    tick();
    v64 = 1'b0;
    #1;
    checks++; if (ov64 !== 64'd0) begin failures++; $display("FAIL single_early act=%h exp=0", ov64); end
    tick();
    #1;
    exp = 64'd1 << 5;
    checks++; if (ov64 !== exp) begin failures++; $display("FAIL single_valid act=%h exp=%h", ov64, exp); end
    checks++; if (lane64(5) !== 8'hA5) begin failures++; $display("FAIL single_data act=%h exp=a5", lane64(5)); end
    tick();
    #1;
    checks++; if (ov64 !== 64'd0) begin failures++; $display("FAIL single_one_cycle act=%h exp=0", ov64); end
  endtask

  task automatic test_sweep();
    logic [63:0] exp;
    logic [7:0]  expd;
    for (int n = 0; n < 66; n++) begin
      if (n < 64) begin
        v64 = 1'b1; s64 = 6'(n); d64 = 8'(n) ^ 8'h3C;
      end else begin
        v64 = 1'b0;
      end
      #1;
      if (n < 64) begin
        checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL sweep_ready n=%0d act=%b exp=1", n, ir64); end
      end
      exp = (n >= 2) ? (64'd1 << (n - 2)) : 64'd0;
      checks++; if (ov64 !== exp) begin failures++; $display("FAIL sweep_valid n=%0d act=%h exp=%h", n, ov64, exp); end
      if (n >= 2) begin
        expd = 8'(n - 2) ^ 8'h3C;
        checks++; if (lane64(n - 2) !== expd) begin failures++; $display("FAIL sweep_data lane=%0d act=%h exp=%h", n - 2, lane64(n - 2), expd); end
      end
      checks++; if (e64 !== 1'b0) begin failures++; $display("FAIL sweep_err n=%0d act=%b exp=0", n, e64); end
      tick();
    end
  endtask

  task automatic test_blocked();
    logic [63:0] exp3, exp4;
    exp3 = 64'd1 << 3;
    exp4 = 64'd1 << 4;
    or64[3] = 1'b0;
    v64 = 1'b1; s64 = 6'd3; d64 = 8'h11;
    tick();
    s64 = 6'd3; d64 = 8'h22;
    tick();
    s64 = 6'd4; d64 = 8'h33;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ir64 !== 1'b0) begin failures++; $display("FAIL blocked_ready i=%0d act=%b exp=0", i, ir64); end
      checks++; if (ov64 !== exp3 || lane64(3) !== 8'h11) begin failures++; $display("FAIL blocked_hold i=%0d act=%h/%h exp=%h/11", i, ov64, lane64(3), exp3); end
      if (i == 0) tick();
    end
    or64[3] = 1'b1;
    #1;
    checks++; if (ir64 !== 1'b1) begin failures++; $display("FAIL unblock_ready act=%b exp=1", ir64); end
    tick();
    v64 = 1'b0;
    #1;
    checks++; if (ov64 !== exp3 || lane64(3) !== 8'h22) begin failures++; $display("FAIL no_bubble act=%h/%h exp=%h/22", ov64, lane64(3), exp3); end
    tick();
    #1;
    checks++; if (ov64 !== exp4 || lane64(4) !== 8'h33) begin failures++; $display("FAIL lane4_after act=%h/%h exp=%h/33", ov64, lane64(4), exp4); end
    tick();
    #1;
    checks++; if (ov64 !== 64'd0) begin failures++; $display("FAIL blocked_empty act=%h exp=0", ov64); end
  endtask

  task automatic test_oor();
    logic [47:0] exp;
    v48 = 1'b1; s48 = 6'd50; d48 = 8'hFF;
    tick();
    s48 = 6'd2; d48 = 8'h02;
    tick();
    v48 = 1'b0;
    #1;
    exp_drop = exp_drop + 1;
    checks++; if (e48 !== 1'b1) begin failures++; $display("FAIL oor_pulse act=%b exp=1", e48); end
    checks++; if (dc48 !== 16'(exp_drop)) begin failures++; $display("FAIL oor_count act=%h exp=%h", dc48, 16'(exp_drop)); end
    checks++; if (ov48 !== 48'd0) begin failures++; $display("FAIL oor_no_lane act=%h exp=0", ov48); end
    tick();
    #1;
    exp = 48'd1 << 2;
    checks++; if (e48 !== 1'b0) begin failures++; $display("FAIL oor_single act=%b exp=0", e48); end
    checks++; if (ov48 !== exp || lane48(2) !== 8'h02) begin failures++; $display("FAIL oor_lane2 act=%h/%h exp=%h/02", ov48, lane48(2), exp); end
    tick();
  endtask

  task automatic test_random();
    int oor_acc  = 0;
    int err_seen = 0;
    int left     = 0;
    logic [47:0]  pv, pr;
    logic [383:0] pd;
    logic [63:0]  r;
    logic [7:0]   expd;
    pv = 48'd0; pr = 48'd0; pd = 384'd0;
    for (int c = 0; c < 3000; c++) begin
      if (c < 2950) begin
        v48 = ($urandom_range(0, 9) < 7);
        s48 = 6'($urandom_range(0, 63));
        d48 = 8'($urandom);
        r = {$urandom, $urandom} | {$urandom, $urandom};
        or48 = r[47:0];
      end else begin
        v48 = 1'b0;
        or48 = {48{1'b1}};
      end
      #1;
      for (int k = 0; k < 48; k++) begin
        if (pv[k] && !pr[k]) begin
          checks++;
          if (ov48[k] !== 1'b1 || od48[k*8 +: 8] !== pd[k*8 +: 8]) begin
            failures++; $display("FAIL rand_stable lane=%0d act=%b/%h exp=1/%h", k, ov48[k], od48[k*8 +: 8], pd[k*8 +: 8]);
          end
        end
        if (ov48[k] && or48[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            failures++; $display("FAIL rand_extra lane=%0d act=%h exp=none", k, od48[k*8 +: 8]);
          end else begin
            expd = exp_q[k].pop_front();
            if (od48[k*8 +: 8] !== expd) begin
              failures++; $display("FAIL rand_data lane=%0d act=%h exp=%h", k, od48[k*8 +: 8], expd);
            end
          end
        end
      end
      if (e48 === 1'b1) err_seen++;
      if (v48 && ir48) begin
        if (s48 >= 6'd48) oor_acc++;
        else exp_q[s48].push_back(d48);
      end
      pv = ov48; pr = or48; pd = od48;
      tick();
    end
    for (int k = 0; k < 48; k++) left += exp_q[k].size();
    exp_drop = exp_drop + oor_acc;
    checks++; if (left != 0) begin failures++; $display("FAIL rand_lost act=%0d exp=0", left); end
    checks++; if (ov48 !== 48'd0) begin failures++; $display("FAIL rand_drained act=%h exp=0", ov48); end
    checks++; if (err_seen != oor_acc) begin failures++; $display("FAIL rand_err_pulses act=%0d exp=%0d", err_seen, oor_acc); end
    checks++; if (dc48 !== 16'(exp_drop)) begin failures++; $display("FAIL rand_drop_cnt act=%h exp=%h", dc48, 16'(exp_drop)); end
  endtask

  task automatic test_saturate();
    int low_ready = 0;
    int low_err   = 0;
    logic [15:0] exp_cnt;
    for (int i = 0; i < 70000; i++) begin
      v48 = 1'b1; s48 = 6'($urandom_range(48, 63)); d48 = 8'($urandom);
      #1;
      if (ir48 !== 1'b1) low_ready++;
      if (i >= 2 && e48 !== 1'b1) low_err++;
      tick();
    end
    v48 = 1'b0;
    tick();
    tick();
    #1;
    exp_drop = exp_drop + 70000;
    exp_cnt = (exp_drop > 65535) ? 16'hFFFF : 16'(exp_drop);
    checks++; if (low_ready != 0) begin failures++; $display("FAIL sat_ready act=%0d exp=0", low_ready); end
    checks++; if (low_err != 0) begin failures++; $display("FAIL sat_err_level act=%0d exp=0", low_err); end
    checks++; if (dc48 !== exp_cnt) begin failures++; $display("FAIL sat_count act=%h exp=%h", dc48, exp_cnt); end
    checks++; if (e48 !== 1'b0) begin failures++; $display("FAIL sat_err_end act=%b exp=0", e48); end
    checks++; if (dc64 !== 16'd0) begin failures++; $display("FAIL pow2_no_drop act=%h exp=0", dc64); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_blocked();
    test_oor();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
